// File: rtl/arb_pkg.sv
// Shared types for the instruction/data RAM port arbiter: read-owner tags,
// system phase encoding and the full-word byte-enable constant.
package arb_pkg;

   // Owner of an outstanding read travelling down the tag pipeline.
   typedef enum logic [1:0] {
      TAG_NONE = 2'd0,
      TAG_LSU  = 2'd1,
      TAG_IF   = 2'd2
   } tag_e;

   // System phase: BOOT while the loader writes the program, RUN afterwards.
   typedef enum logic {
      PH_BOOT = 1'b0,
      PH_RUN  = 1'b1
   } phase_e;

   localparam logic [3:0] BE_FULL = 4'hF;

endpackage

// File: rtl/arb_rd_tag_pipe.sv
// Read-owner tag shift register. A tag pushed in the grant cycle reaches the
// last stage RD_LATENCY cycles later, lining up with the RAM read data.
module arb_rd_tag_pipe
   import arb_pkg::*;
#(
   parameter int unsigned RD_LATENCY = 1
) (
   input  logic clk_i,
   input  logic rst_i,
   input  tag_e tag_i,
   output logic lsu_rvalid_o,
   output logic if_rvalid_o
);

   tag_e tag_q [RD_LATENCY];

   // Shift tags one stage per cycle; reset flushes every in-flight read.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         for (int unsigned i = 0; i < RD_LATENCY; i++) begin
            tag_q[i] <= TAG_NONE;
         end
      end else begin
         tag_q[0] <= tag_i;
         for (int unsigned i = 1; i < RD_LATENCY; i++) begin
            tag_q[i] <= tag_q[i-1];
         end
      end
   end

   // Decode the last stage; suppressed while rst is high so a read granted
   // just before reset never reports valid data.
   always_comb begin
      lsu_rvalid_o = !rst_i && (tag_q[RD_LATENCY-1] == TAG_LSU);
      if_rvalid_o  = !rst_i && (tag_q[RD_LATENCY-1] == TAG_IF);
   end

endmodule

// File: rtl/imem_dmem_port_arbiter.sv
// Single-port program/data RAM arbiter: the UART loader owns the port in BOOT,
// the LSU and instruction fetch share it in RUN with an anti-starvation flip
// to fetch priority. Optional perf counters: define ARB_PERF_CNT_EN.
module imem_dmem_port_arbiter
   import arb_pkg::*;
#(
   parameter int unsigned ADDR_W     = 10,
   parameter int unsigned RD_LATENCY = 1,
   parameter int unsigned STARVE_MAX = 4
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              ldr_req_i,
   input  logic [ADDR_W-1:0] ldr_addr_i,
   input  logic [31:0]       ldr_wdata_i,
   input  logic              ldr_done_i,
   output logic              ldr_gnt_o,
   input  logic              lsu_req_i,
   input  logic              lsu_we_i,
   input  logic [3:0]        lsu_be_i,
   input  logic [ADDR_W-1:0] lsu_addr_i,
   input  logic [31:0]       lsu_wdata_i,
   output logic              lsu_gnt_o,
   output logic              lsu_rvalid_o,
   input  logic              if_req_i,
   input  logic [ADDR_W-1:0] if_addr_i,
   output logic              if_gnt_o,
   output logic              if_rvalid_o,
   output logic [31:0]       rdata_o,
   output logic              mem_en_o,
   output logic [3:0]        mem_we_o,
   output logic [ADDR_W-1:0] mem_addr_o,
   output logic [31:0]       mem_wdata_o,
   input  logic [31:0]       mem_rdata_i,
   output logic              cpu_stall_o
`ifdef ARB_PERF_CNT_EN
   ,
   output logic [31:0]       perf_conflicts_o,
   output logic [15:0]       perf_starve_hits_o
`endif
);

   localparam logic [3:0] StarveMax = 4'(STARVE_MAX);

   phase_e     phase_q, phase_d;
   logic [3:0] starve_cnt_q, starve_cnt_d;
   tag_e       tag_d;
   logic       force_if;

   // Phase and starvation counter registers.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         phase_q      <= PH_BOOT;
         starve_cnt_q <= '0;
      end else begin
         phase_q      <= phase_d;
         starve_cnt_q <= starve_cnt_d;
      end
   end

   // Grant selection and RAM command, combinational in the request cycle.
   always_comb begin
      ldr_gnt_o   = 1'b0;
      lsu_gnt_o   = 1'b0;
      if_gnt_o    = 1'b0;
      mem_en_o    = 1'b0;
      mem_we_o    = '0;
      mem_addr_o  = '0;
      mem_wdata_o = '0;
      tag_d       = TAG_NONE;
      force_if    = 1'b0;
      if (phase_q == PH_BOOT) begin
         if (ldr_req_i) begin
            ldr_gnt_o   = 1'b1;
            mem_en_o    = 1'b1;
            mem_we_o    = BE_FULL;
            mem_addr_o  = ldr_addr_i;
            mem_wdata_o = ldr_wdata_i;
         end
      end else begin
         force_if = if_req_i && (starve_cnt_q == StarveMax);
         if (force_if) begin
            if_gnt_o = 1'b1;
         end else if (lsu_req_i) begin
            lsu_gnt_o = 1'b1;
         end else if (if_req_i) begin
            if_gnt_o = 1'b1;
         end
         if (lsu_gnt_o) begin
            mem_en_o    = 1'b1;
            mem_we_o    = lsu_we_i ? lsu_be_i : 4'h0;
            mem_addr_o  = lsu_addr_i;
            mem_wdata_o = lsu_wdata_i;
            tag_d       = lsu_we_i ? TAG_NONE : TAG_LSU;
         end else if (if_gnt_o) begin
            mem_en_o   = 1'b1;
            mem_addr_o = if_addr_i;
            tag_d      = TAG_IF;
         end
      end
   end

   // Phase advance after ldr_done; starvation count of denied fetch cycles.
   always_comb begin
      phase_d      = phase_q;
      starve_cnt_d = '0;
      if (phase_q == PH_BOOT) begin
         if (ldr_done_i) begin
            phase_d = PH_RUN;
         end
      end else if (if_req_i && !if_gnt_o) begin
         starve_cnt_d = (starve_cnt_q == StarveMax) ? starve_cnt_q : starve_cnt_q + 4'd1;
      end
   end

   // Core is held for the whole BOOT phase; read data only shown with a valid.
   always_comb begin
      cpu_stall_o = (phase_q == PH_BOOT);
      rdata_o     = (lsu_rvalid_o || if_rvalid_o) ? mem_rdata_i : 32'h0;
   end

   arb_rd_tag_pipe #(
      .RD_LATENCY (RD_LATENCY)
   ) u_rd_tag_pipe (
      .clk_i        (clk_i),
      .rst_i        (rst_i),
      .tag_i        (tag_d),
      .lsu_rvalid_o (lsu_rvalid_o),
      .if_rvalid_o  (if_rvalid_o)
   );

`ifdef ARB_PERF_CNT_EN
   logic [31:0] perf_conflicts_q;
   logic [15:0] perf_starve_hits_q;

   // Saturating RUN-phase contention and forced-fetch counters.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         perf_conflicts_q   <= '0;
         perf_starve_hits_q <= '0;
      end else begin
         if (phase_q == PH_RUN && lsu_req_i && if_req_i && perf_conflicts_q != '1) begin
            perf_conflicts_q <= perf_conflicts_q + 32'd1;
         end
         if (force_if && perf_starve_hits_q != '1) begin
            perf_starve_hits_q <= perf_starve_hits_q + 16'd1;
         end
      end
   end

   assign perf_conflicts_o   = perf_conflicts_q;
   assign perf_starve_hits_o = perf_starve_hits_q;
`else
   // Counters absent: force_if only steers the grant.
`endif

endmodule

// File: tb/tb_imem_dmem_port_arbiter.sv
// Directed bench: two arbiters (RD_LATENCY 1 and 2) driven by the same
// requesters, each with its own behavioural RAM of matching latency.
module tb_imem_dmem_port_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        ldr_req, ldr_done, lsu_req, lsu_we, if_req;
   logic [9:0]  ldr_addr, lsu_addr, if_addr;
   logic [31:0] ldr_wdata, lsu_wdata;
   logic [3:0]  lsu_be;

   logic        ldr_gnt1, lsu_gnt1, lsu_rv1, if_gnt1, if_rv1, en1, stall1;
   logic [31:0] rdata1, wdata1, mrd1;
   logic [3:0]  we1;
   logic [9:0]  addr1;
   logic        ldr_gnt2, lsu_gnt2, lsu_rv2, if_gnt2, if_rv2, en2, stall2;
   logic [31:0] rdata2, wdata2, mrd2;
   logic [3:0]  we2;
   logic [9:0]  addr2;
`ifdef ARB_PERF_CNT_EN
   logic [31:0] pc1, pc2;
   logic [15:0] ps1, ps2;
`endif

   int n_total = 0;
   int n_bad   = 0;

   always #5 clk = ~clk;

   imem_dmem_port_arbiter #(.ADDR_W(10), .RD_LATENCY(1), .STARVE_MAX(4)) u_dut1 (
      .clk_i(clk), .rst_i(rst),
      .ldr_req_i(ldr_req), .ldr_addr_i(ldr_addr), .ldr_wdata_i(ldr_wdata),
      .ldr_done_i(ldr_done), .ldr_gnt_o(ldr_gnt1),
      .lsu_req_i(lsu_req), .lsu_we_i(lsu_we), .lsu_be_i(lsu_be), .lsu_addr_i(lsu_addr),
      .lsu_wdata_i(lsu_wdata), .lsu_gnt_o(lsu_gnt1), .lsu_rvalid_o(lsu_rv1),
      .if_req_i(if_req), .if_addr_i(if_addr), .if_gnt_o(if_gnt1), .if_rvalid_o(if_rv1),
      .rdata_o(rdata1), .mem_en_o(en1), .mem_we_o(we1), .mem_addr_o(addr1),
      .mem_wdata_o(wdata1), .mem_rdata_i(mrd1), .cpu_stall_o(stall1)
`ifdef ARB_PERF_CNT_EN
      , .perf_conflicts_o(pc1), .perf_starve_hits_o(ps1)
`endif
   );

   imem_dmem_port_arbiter #(.ADDR_W(10), .RD_LATENCY(2), .STARVE_MAX(4)) u_dut2 (
      .clk_i(clk), .rst_i(rst),
      .ldr_req_i(ldr_req), .ldr_addr_i(ldr_addr), .ldr_wdata_i(ldr_wdata),
      .ldr_done_i(ldr_done), .ldr_gnt_o(ldr_gnt2),
      .lsu_req_i(lsu_req), .lsu_we_i(lsu_we), .lsu_be_i(lsu_be), .lsu_addr_i(lsu_addr),
      .lsu_wdata_i(lsu_wdata), .lsu_gnt_o(lsu_gnt2), .lsu_rvalid_o(lsu_rv2),
      .if_req_i(if_req), .if_addr_i(if_addr), .if_gnt_o(if_gnt2), .if_rvalid_o(if_rv2),
      .rdata_o(rdata2), .mem_en_o(en2), .mem_we_o(we2), .mem_addr_o(addr2),
      .mem_wdata_o(wdata2), .mem_rdata_i(mrd2), .cpu_stall_o(stall2)
`ifdef ARB_PERF_CNT_EN
      , .perf_conflicts_o(pc2), .perf_starve_hits_o(ps2)
`endif
   );

   // Behavioural RAMs: byte-enabled writes, reads delayed by 1 and 2 cycles.
   logic [31:0] ram1 [1024];
   logic [31:0] ram2 [1024];
   logic [31:0] rd1_q;
   logic [31:0] rd2_q [2];

   initial begin
      for (int i = 0; i < 1024; i++) begin
         ram1[i] = 32'h0;
         ram2[i] = 32'h0;
      end
      rd1_q    = 32'h0;
      rd2_q[0] = 32'h0;
      rd2_q[1] = 32'h0;
   end

   always @(posedge clk) begin
      if (en1) begin
         rd1_q <= ram1[addr1];
         for (int b = 0; b < 4; b++) if (we1[b]) ram1[addr1][8*b +: 8] <= wdata1[8*b +: 8];
      end
      if (en2) begin
         rd2_q[0] <= ram2[addr2];
         for (int b = 0; b < 4; b++) if (we2[b]) ram2[addr2][8*b +: 8] <= wdata2[8*b +: 8];
      end
      rd2_q[1] <= rd2_q[0];
   end

   assign mrd1 = rd1_q;
   assign mrd2 = rd2_q[1];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic idle_inputs();
      ldr_req = 0; ldr_done = 0; ldr_addr = '0; ldr_wdata = '0;
      lsu_req = 0; lsu_we = 0; lsu_be = '0; lsu_addr = '0; lsu_wdata = '0;
      if_req = 0; if_addr = '0;
   endtask

   // Inputs change on the falling edge; checks follow 1 time unit later.
   task automatic next_cycle();
      @(negedge clk);
   endtask

   initial begin
      rst = 1'b1;
      idle_inputs();
      repeat (2) next_cycle();
      #1;
      check("rst_stall", stall1, 1);
      check("rst_en", en1, 0);
      check("rst_we", we1, 0);
      check("rst_gnts", {ldr_gnt1, lsu_gnt1, if_gnt1}, 0);
      check("rst_rvalid", {lsu_rv1, if_rv1, lsu_rv2, if_rv2}, 0);
      check("rst_rdata", rdata1, 0);

      // Boot: loader writes while fetch is already requesting.
      next_cycle(); rst = 0;
      ldr_req = 1; ldr_addr = 10'd1; ldr_wdata = 32'hAAAA0001; if_req = 1; if_addr = 10'd3;
      #1;
      check("boot_ldr_gnt", ldr_gnt1, 1);
      check("boot_we", we1, 4'hF);
      check("boot_if_gnt", if_gnt1, 0);
      check("boot_stall", stall1, 1);
      check("boot_addr", addr1, 10'd1);
      next_cycle(); ldr_addr = 10'd2; ldr_wdata = 32'hBBBB0002;
      #1;
      check("boot_wdata", wdata1, 32'hBBBB0002);
      next_cycle(); ldr_addr = 10'd3; ldr_wdata = 32'h00708093; ldr_done = 1;
      lsu_req = 1;
      #1;
      check("done_ldr_gnt", ldr_gnt1, 1);
      check("done_we", we2, 4'hF);
      check("done_stall", stall1, 1);
      check("boot_lsu_gnt", lsu_gnt1, 0);

      // First RUN cycle: stall drops, fetch of the just-written word.
      next_cycle(); ldr_req = 0; ldr_done = 0; lsu_req = 0;
      #1;
      check("run_stall", {stall1, stall2}, 0);
      check("run_ldr_gnt", ldr_gnt1, 0);
      check("run_if_gnt", if_gnt1, 1);
      check("run_mem_addr", addr1, 10'd3);
      check("run_mem_we", we1, 0);
      next_cycle(); if_req = 0;
      #1;
      check("fetch1_rvalid", if_rv1, 1);
      check("fetch1_rdata", rdata1, 32'h00708093);
      check("fetch2_early", if_rv2, 0);
      next_cycle();
      #1;
      check("fetch2_rvalid", if_rv2, 1);
      check("fetch2_rdata", rdata2, 32'h00708093);
      check("fetch1_single", if_rv1, 0);

      // Contention: LSU wins four cycles, fetch the fifth, repeating.
      next_cycle();
      lsu_req = 1; lsu_addr = 10'd1; if_req = 1; if_addr = 10'd2;
      for (int k = 0; k < 10; k++) begin
         #1;
         check($sformatf("cont%0d_if", k), if_gnt1, ((k % 5) == 4) ? 1 : 0);
         check($sformatf("cont%0d_lsu", k), lsu_gnt1, ((k % 5) == 4) ? 0 : 1);
`ifdef ARB_PERF_CNT_EN
         if (k == 5) begin
            check("perf_starve", ps1, 1);
            check("perf_conf", pc1, 5);
         end
`endif
         next_cycle();
      end
      idle_inputs();
      #1;
      check("idle_en", en1, 0);
      check("idle_bus", {we1, addr1, wdata1}, 0);
      repeat (3) next_cycle();

      // Byte store, then read it back through the LSU.
      lsu_req = 1; lsu_we = 1; lsu_be = 4'b0010; lsu_addr = 10'd5; lsu_wdata = 32'h0000AB00;
      #1;
      check("st_gnt", lsu_gnt1, 1);
      check("st_we", we1, 4'b0010);
      check("st_addr", addr1, 10'd5);
      next_cycle(); lsu_we = 0; lsu_be = 4'h0;
      #1;
      check("st_no_rv1", lsu_rv1, 0);
      next_cycle(); lsu_req = 0;
      #1;
      check("st_no_rv2", lsu_rv2, 0);
      check("ld5_rv1", lsu_rv1, 1);
      check("ld5_rdata", rdata1, 32'h0000AB00);
      repeat (2) next_cycle();

      // Pipelined reads: LSU addr 1 then fetch addr 2.
      lsu_req = 1; lsu_addr = 10'd1;
      #1;
      check("pipe_lsu_gnt", lsu_gnt2, 1);
      next_cycle(); lsu_req = 0; if_req = 1; if_addr = 10'd2;
      #1;
      check("pipe_if_gnt", if_gnt2, 1);
      check("pipe1_lsu_rv", lsu_rv1, 1);
      check("pipe1_lsu_data", rdata1, 32'hAAAA0001);
      next_cycle(); if_req = 0;
      #1;
      check("pipe2_t2", {lsu_rv2, if_rv2}, 2'b10);
      check("pipe2_t2_data", rdata2, 32'hAAAA0001);
      check("pipe1_if_data", rdata1, 32'hBBBB0002);
      next_cycle();
      #1;
      check("pipe2_t3", {lsu_rv2, if_rv2}, 2'b01);
      check("pipe2_t3_data", rdata2, 32'hBBBB0002);
      repeat (2) next_cycle();

      // Reset the cycle after an LSU read grant.
      lsu_req = 1; lsu_addr = 10'd1;
      #1;
      check("rmr_gnt", lsu_gnt1, 1);
      next_cycle(); lsu_req = 0; rst = 1;
      #1;
      check("rmr_rv1_rst", lsu_rv1, 0);
      next_cycle(); rst = 0;
      #1;
      check("rmr_rv", {lsu_rv1, lsu_rv2}, 0);
      check("rmr_stall", {stall1, stall2}, 2'b11);
      next_cycle(); lsu_req = 1; if_req = 1;
      #1;
      check("rmr_rv2_late", lsu_rv2, 0);
      check("rmr_boot_gnts", {lsu_gnt1, if_gnt1}, 0);
      next_cycle();
      idle_inputs();

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule

// File: doc/imem_dmem_port_arbiter.md
Name: imem_dmem_port_arbiter

Overview:
- Shares the CPU's single-port 32-bit program/data RAM between three requesters: the UART boot loader, the load/store unit (LSU) and instruction fetch.
- Sequences the two system phases:
  - BOOT: the UART writes the program and the core is stalled.
  - RUN: fetch and LSU compete for the port.
- Sits inside cpu_uart_top, between the requesters and the RAM macro.
- Guarantees that a fetch is never starved by back-to-back loads and stores.

Parameters:
- ADDR_W, 10, word-address width (1024 cells).
- RD_LATENCY, 1, RAM read latency in cycles (1..3).
- STARVE_MAX, 4, consecutive denied fetch cycles before fetch gets priority (1..15).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- ldr_req  in  1  loader write request.
- ldr_addr  in  ADDR_W  loader word address.
- ldr_wdata  in  32  loader write data.
- ldr_done  in  1  loader finished; one-cycle pulse.
- ldr_gnt  out  1  loader write accepted this cycle.
- lsu_req  in  1  LSU request.
- lsu_we  in  1  1 = store.
- lsu_be  in  4  store byte enables.
- lsu_addr  in  ADDR_W  LSU word address.
- lsu_wdata  in  32  store data.
- lsu_gnt  out  1  LSU request accepted.
- lsu_rvalid  out  1  load data valid.
- if_req  in  1  fetch request.
- if_addr  in  ADDR_W  fetch word address.
- if_gnt  out  1  fetch accepted.
- if_rvalid  out  1  instruction valid.
- rdata  out  32  read data; routed to whichever rvalid is high.
- mem_en  out  1  RAM enable.
- mem_we  out  4  RAM byte write enables.
- mem_addr  out  ADDR_W  RAM address.
- mem_wdata  out  32  RAM write data.
- mem_rdata  in  32  RAM read data.
- cpu_stall  out  1  core held while in BOOT.

Behaviour:
- Phase FSM, states BOOT and RUN:
  - Reset puts the FSM in BOOT.
  - BOOT -> RUN on the cycle after ldr_done is sampled high.
  - RUN -> BOOT only by rst.
- cpu_stall = (state == BOOT). It deasserts the first cycle in RUN.
- BOOT arbitration:
  - Only the loader can be granted: ldr_gnt = ldr_req.
  - The winning write drives mem_we = 4'hF.
  - lsu_gnt and if_gnt are held at 0.
  - If ldr_req and ldr_done are high in the same cycle, the write is still performed.
- RUN arbitration:
  - ldr_gnt is held at 0.
  - Default priority is LSU over fetch.
  - Priority flips to fetch when starve_cnt == STARVE_MAX.
- Grants and the memory command are combinational in the request cycle. A transfer happens when req and gnt are both high.
- Loser handshake: the losing requester keeps its request and payload stable until granted.
- Starvation counter starve_cnt:
  - Increments each RUN cycle in which if_req is high and if_gnt is low; saturates at STARVE_MAX.
  - Clears on if_gnt or when if_req is low.
- Read return:
  - Each accepted read pushes an owner tag (LSU or IF) into a RD_LATENCY-deep shift register.
  - The matching rvalid pulses exactly RD_LATENCY cycles after the grant.
  - rdata = mem_rdata.
  - Stores and loader writes produce no rvalid.
- Pipelining: one grant per cycle and back-to-back reads are fully pipelined. Reads accepted in consecutive cycles return in consecutive cycles, in order.
- Idle memory outputs (no grant): mem_en = 0, mem_we = 0, mem_addr and mem_wdata are don't-care but driven to 0.
- Reset values: all gnt and rvalid outputs 0, cpu_stall = 1, mem_en = 0, mem_we = 0, rdata = 0, tag pipeline empty, starve_cnt = 0.
- Reset mid-read: the tag pipeline is flushed and no rvalid is emitted for reads granted before rst.

Optional Feature:
- Macro ARB_PERF_CNT_EN.
- When defined:
  - Adds output perf_conflicts [31:0]: counts RUN cycles with lsu_req && if_req both high.
  - Adds output perf_starve_hits [15:0]: counts forced fetch-priority grants.
  - Both counters saturate and are cleared by rst.
- When undefined, the ports and logic are absent and the behaviour is otherwise identical.

Decomposition:
- Shared package arb_pkg holds:
  - owner tag typedef (TAG_NONE, TAG_LSU, TAG_IF);
  - phase enum (PH_BOOT, PH_RUN);
  - constant BE_FULL = 4'hF.
- One sub-module, arb_rd_tag_pipe: the RD_LATENCY-deep tag shift register that generates lsu_rvalid and if_rvalid.

Test Plan:
- Boot load: after rst, loader writes 'h00708093 to address 3 while if_req = 1.
  - Required: ldr_gnt = 1, mem_we = 4'hF, if_gnt = 0, cpu_stall = 1.
  - Pulse ldr_done: cpu_stall drops exactly one cycle later.
- Fetch read-back in RUN: if_req at address 3 -> if_gnt = 1, then if_rvalid = 1 with rdata = 'h00708093 after RD_LATENCY = 1 cycle.
- Contention: lsu_req and if_req held high continuously.
  - Required: LSU wins 4 cycles, fetch wins the 5th cycle (starve_cnt = 4), pattern repeats.
  - With ARB_PERF_CNT_EN: perf_starve_hits = 1 after 5 cycles.
- Byte store: lsu_we = 1, lsu_be = 4'b0010, addr 5 -> mem_we = 4'b0010 and no lsu_rvalid.
- Pipelined reads: LSU read addr 1, then fetch read addr 2 in the next cycle, with RD_LATENCY = 2.
  - Required: lsu_rvalid at t+2, if_rvalid at t+3, in order.
- Reset mid-read: assert rst the cycle after an LSU read grant.
  - Required: no lsu_rvalid, FSM back in BOOT, cpu_stall = 1.
